// File: rtl/pipeline_ctrl_if.sv
// Control-bus bundle between the hazard/redirect controller and the pipeline.
// The slave side belongs to pipeline_ctrl; the master side to whoever drives requests.
interface pipeline_ctrl_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 64
);
   logic             if_stall_req_i;
   logic             id_stall_req_i;
   logic             ex_stall_req_i;
   logic             mem_stall_req_i;
   logic             ex_redirect_valid_i;
   logic [XLEN-1:0]  ex_redirect_pc_i;
   logic             trap_valid_i;
   logic [XLEN-1:0]  trap_pc_i;
   logic [5:0]       stall_valid_o;
   logic [5:0]       flush_valid_o;
   logic             redirect_valid_o;
   logic [XLEN-1:0]  redirect_pc_o;
   logic [CNT_W-1:0] stall_cycles_o;
   logic [CNT_W-1:0] bubble_cycles_o;

   modport master (
      output if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
      output ex_redirect_valid_i, ex_redirect_pc_i, trap_valid_i, trap_pc_i,
      input  stall_valid_o, flush_valid_o, redirect_valid_o, redirect_pc_o,
      input  stall_cycles_o, bubble_cycles_o
   );

   modport slave (
      input  if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
      input  ex_redirect_valid_i, ex_redirect_pc_i, trap_valid_i, trap_pc_i,
      output stall_valid_o, flush_valid_o, redirect_valid_o, redirect_pc_o,
      output stall_cycles_o, bubble_cycles_o
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard and redirect controller: per-register stall/flush vectors, PC redirect
// (held pending across an uncancellable fetch) and stall/bubble statistics.
module pipeline_ctrl #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 64
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.slave bus
);
   typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

   state_t           r_state, w_state_nxt;
   logic [XLEN-1:0]  r_pend_pc, w_pend_pc_nxt;
   logic             r_pend_is_trap, w_pend_is_trap_nxt;
   logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

   logic [5:0]       w_stall, w_flush;
   logic             w_redir_v;
   logic [XLEN-1:0]  w_redir_pc, w_target;
   logic             w_trap_blk, w_trap_acc, w_ex_acc, w_acc;

   // A trap stuck behind MEM freezes the whole pipe; a pending trap masks later branches.
   assign w_trap_blk = bus.trap_valid_i & bus.mem_stall_req_i;
   assign w_trap_acc = bus.trap_valid_i & ~bus.mem_stall_req_i;
   assign w_ex_acc   = bus.ex_redirect_valid_i & ~bus.mem_stall_req_i & ~bus.ex_stall_req_i
                     & ~w_trap_acc & ~((r_state == S_PEND) & r_pend_is_trap);
   assign w_acc      = w_trap_acc | w_ex_acc;
   assign w_target   = w_trap_acc ? bus.trap_pc_i : bus.ex_redirect_pc_i;

   always_comb begin
      w_state_nxt        = r_state;
      w_pend_pc_nxt      = r_pend_pc;
      w_pend_is_trap_nxt = r_pend_is_trap;
      w_stall            = 6'b000000;
      w_flush            = 6'b000000;
      w_redir_v          = 1'b0;
      w_redir_pc         = '0;

      if (bus.mem_stall_req_i) begin
         w_stall = 6'b001111; w_flush = 6'b010000;
      end else if (bus.ex_stall_req_i) begin
         w_stall = 6'b000111; w_flush = 6'b001000;
      end else if (bus.id_stall_req_i) begin
         w_stall = 6'b000011; w_flush = 6'b000100;
      end else if (bus.if_stall_req_i) begin
         w_stall = 6'b000001; w_flush = 6'b000010;
      end

      if (rst) begin
         w_stall = 6'b000000;
         w_flush = 6'b111110;
      end else if (w_trap_blk) begin
         w_stall = 6'b111111;
         w_flush = 6'b000000;
      end else begin
         if (w_trap_acc) begin
            w_stall = 6'b000000;
            w_flush = 6'b011110;
         end else if (w_ex_acc) begin
            w_stall[2:0] = 3'b000;
            w_flush[2:1] = 2'b11;
         end

         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  if (bus.if_stall_req_i) begin
                     w_stall[0]         = 1'b1;
                     w_state_nxt        = S_PEND;
                     w_pend_pc_nxt      = w_target;
                     w_pend_is_trap_nxt = w_trap_acc;
                  end else begin
                     w_redir_v  = 1'b1;
                     w_redir_pc = w_target;
                  end
               end
            end
            S_PEND: begin
               // Hold the PC and bubble IF/ID so the stale fetch never enters decode.
               w_stall[1:0] = 2'b01;
               w_flush[1:0] = 2'b10;
               if (w_acc) begin
                  w_pend_pc_nxt      = w_target;
                  w_pend_is_trap_nxt = r_pend_is_trap | w_trap_acc;
               end
               if (!bus.if_stall_req_i) begin
                  w_stall[0]         = 1'b0;
                  w_redir_v          = 1'b1;
                  w_redir_pc         = w_acc ? w_target : r_pend_pc;
                  w_state_nxt        = S_IDLE;
                  w_pend_is_trap_nxt = 1'b0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_pend_pc      <= '0;
         r_pend_is_trap <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_pend_pc      <= w_pend_pc_nxt;
         r_pend_is_trap <= w_pend_is_trap_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         r_stall_cnt  <= r_stall_cnt  + CNT_W'(|w_stall);
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(|w_flush);
      end
   end

   assign bus.stall_valid_o    = w_stall;
   assign bus.flush_valid_o    = w_flush;
   assign bus.redirect_valid_o = w_redir_v;
   assign bus.redirect_pc_o    = w_redir_pc;
   assign bus.stall_cycles_o   = r_stall_cnt;
   assign bus.bubble_cycles_o  = r_bubble_cnt;
endmodule
